// File: rtl/conv_pkg.sv
// Shared geometry and state encoding for the convolution sequencer.
package conv_pkg;
  localparam int IMG_W    = 8;
  localparam int IMG_H    = 8;
  localparam int K        = 3;
  localparam int OUT_W    = IMG_W - K + 1;
  localparam int OUT_H    = IMG_H - K + 1;
  localparam int ADDR_W   = 6;
  localparam int DATA_W   = 8;
  localparam int TAP_W    = 4;
  localparam int NPIX     = IMG_W * IMG_H;
  localparam int IMG_W_LG = $clog2(IMG_W);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CONV,
    ST_DRAIN,
    ST_DONE
  } state_e;
endpackage

// File: rtl/conv_win_addr_gen.sv
// KxK window walker: kx fastest, then ky, then output column, then output row.
module conv_win_addr_gen
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step_i,
  input  logic              clear_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [TAP_W-1:0]  tap_o,
  output logic              last_tap_o,
  output logic              last_pixel_o
);
  logic [ADDR_W-1:0] kx_q, ky_q, c_q, r_q;
  logic [ADDR_W-1:0] row, col;

  always_comb begin
    row          = r_q + ky_q;
    col          = c_q + kx_q;
    // image width is a power of two, so the row offset is a shift
    addr_o       = (row << IMG_W_LG) + col;
    tap_o        = TAP_W'(ky_q * ADDR_W'(K) + kx_q);
    last_tap_o   = (kx_q == ADDR_W'(K - 1)) && (ky_q == ADDR_W'(K - 1));
    last_pixel_o = (c_q == ADDR_W'(OUT_W - 1)) && (r_q == ADDR_W'(OUT_H - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kx_q <= '0;
      ky_q <= '0;
      c_q  <= '0;
      r_q  <= '0;
    end else if (clear_i) begin
      kx_q <= '0;
      ky_q <= '0;
      c_q  <= '0;
      r_q  <= '0;
    end else if (step_i) begin
      if (kx_q != ADDR_W'(K - 1)) begin
        kx_q <= kx_q + 1'b1;
      end else begin
        kx_q <= '0;
        if (ky_q != ADDR_W'(K - 1)) begin
          ky_q <= ky_q + 1'b1;
        end else begin
          ky_q <= '0;
          if (c_q != ADDR_W'(OUT_W - 1)) begin
            c_q <= c_q + 1'b1;
          end else begin
            c_q <= '0;
            r_q <= (r_q == ADDR_W'(OUT_H - 1)) ? '0 : r_q + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: rtl/conv_seq_ctrl.sv
// Convolution sequencer: image load into RAM, then window walk driving RAM reads and MAC control.
module conv_seq_ctrl
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_st_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              start_i,
  output logic              ram_wr_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_din_o,
  output logic [TAP_W-1:0]  tap_idx_o,
  output logic              mac_clr_o,
  output logic              mac_en_o,
  output logic              out_st_o,
  output logic [ADDR_W-1:0] out_idx_o,
  output logic              loaded_o,
  output logic              busy_o,
  output logic              done_o
);
  state_e            state_q;
  logic [ADDR_W-1:0] wr_cnt_q, out_cnt_q;
  logic              loaded_q, done_q;
  logic              ram_wr_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_din_q;
  // vld_pipe_q[0]: read issued (address on the RAM port), [1]: MAC consuming
  logic [1:0]        vld_pipe_q;
  logic [TAP_W-1:0]  iss_tap_q, tap_idx_q;
  logic              iss_last_q, mac_last_q, mac_clr_q;
  logic              out_st_q;
  logic [ADDR_W-1:0] out_idx_q;

  logic              go_conv, issue, gen_clear;
  logic [ADDR_W-1:0] gen_addr;
  logic [TAP_W-1:0]  gen_tap;
  logic              gen_last_tap, gen_last_pixel;

  // the IDLE->CONV edge already issues tap 0, so there is no bubble at start
  always_comb begin
    go_conv   = (state_q == ST_IDLE) && !in_st_i && start_i && loaded_q;
    issue     = go_conv || (state_q == ST_CONV);
    gen_clear = (state_q == ST_IDLE) && !go_conv;
  end

  conv_win_addr_gen u_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .step_i       (issue),
    .clear_i      (gen_clear),
    .addr_o       (gen_addr),
    .tap_o        (gen_tap),
    .last_tap_o   (gen_last_tap),
    .last_pixel_o (gen_last_pixel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_cnt_q   <= '0;
      out_cnt_q  <= '0;
      loaded_q   <= 1'b0;
      done_q     <= 1'b0;
      ram_wr_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      vld_pipe_q <= '0;
      iss_tap_q  <= '0;
      iss_last_q <= 1'b0;
      tap_idx_q  <= '0;
      mac_clr_q  <= 1'b0;
      mac_last_q <= 1'b0;
      out_st_q   <= 1'b0;
      out_idx_q  <= '0;
    end else begin
      ram_wr_q   <= 1'b0;
      done_q     <= 1'b0;
      vld_pipe_q <= {vld_pipe_q[0], issue};
      iss_tap_q  <= issue ? gen_tap : '0;
      iss_last_q <= issue && gen_last_tap;
      tap_idx_q  <= iss_tap_q;
      mac_clr_q  <= vld_pipe_q[0] && (iss_tap_q == '0);
      mac_last_q <= iss_last_q;
      out_st_q   <= mac_last_q;
      out_idx_q  <= mac_last_q ? out_cnt_q : '0;
      if (mac_last_q) out_cnt_q <= out_cnt_q + 1'b1;
      if (issue) ram_addr_q <= gen_addr;

      unique case (state_q)
        ST_IDLE: begin
          if (in_st_i) begin
            state_q    <= ST_LOAD;
            loaded_q   <= 1'b0;
            ram_wr_q   <= 1'b1;
            ram_addr_q <= '0;
            ram_din_q  <= in_data_i;
            wr_cnt_q   <= ADDR_W'(1);
          end else if (go_conv) begin
            state_q   <= ST_CONV;
            out_cnt_q <= '0;
          end
        end
        ST_LOAD: begin
          if (in_st_i) begin
            ram_wr_q   <= 1'b1;
            ram_addr_q <= wr_cnt_q;
            ram_din_q  <= in_data_i;
            wr_cnt_q   <= wr_cnt_q + 1'b1;
            if (wr_cnt_q == ADDR_W'(NPIX - 1)) begin
              state_q  <= ST_IDLE;
              loaded_q <= 1'b1;
              wr_cnt_q <= '0;
            end
          end
        end
        ST_CONV: begin
          if (gen_last_tap && gen_last_pixel) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (out_st_q) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ram_wr_o   = ram_wr_q;
  assign ram_addr_o = ram_addr_q;
  assign ram_din_o  = ram_din_q;
  assign tap_idx_o  = tap_idx_q;
  assign mac_clr_o  = mac_clr_q;
  assign mac_en_o   = vld_pipe_q[1];
  assign out_st_o   = out_st_q;
  assign out_idx_o  = out_idx_q;
  assign loaded_o   = loaded_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = done_q;
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Scoreboard bench for conv_seq_ctrl with behavioural RAM and all-ones-kernel MAC.
module tb_conv_seq_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0, in_st = 1'b0, start = 1'b0;
  logic [7:0] in_data = '0;
  logic       ram_wr, mac_clr, mac_en, out_st, loaded, busy, done;
  logic [5:0] ram_addr, out_idx;
  logic [7:0] ram_din;
  logic [3:0] tap_idx;

  always #5 clk = ~clk;

  conv_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_st_i(in_st), .in_data_i(in_data), .start_i(start),
    .ram_wr_o(ram_wr), .ram_addr_o(ram_addr), .ram_din_o(ram_din), .tap_idx_o(tap_idx),
    .mac_clr_o(mac_clr), .mac_en_o(mac_en), .out_st_o(out_st), .out_idx_o(out_idx),
    .loaded_o(loaded), .busy_o(busy), .done_o(done)
  );

  logic [7:0]         mem [64];
  logic [7:0]         ram_dout;
  logic signed [31:0] acc;
  int                 img_ref [64];

  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
    if (mac_en) acc <= mac_clr ? 32'($signed(ram_dout)) : acc + 32'($signed(ram_dout));
  end

  typedef struct { int addr; int data; } wexp_t;
  typedef struct { int idx; int val; int cyc; } oexp_t;
  wexp_t wq[$];
  oexp_t oq[$];
  int tests = 0, fails = 0;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({ram_wr, ram_addr, ram_din, tap_idx, mac_clr, mac_en, out_st, out_idx, done} !== '0) begin
      fails++; $display("FAIL reset_outputs: got nonzero outputs, required all 0"); end
    tests++;
    if ({loaded, busy} !== 2'b00) begin
      fails++; $display("FAIL reset_state: loaded/busy=%b, required 00", {loaded, busy}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_start_unloaded();
    start = 1'b1;
    repeat (4) begin
      @(negedge clk);
      tests++;
      if ({busy, mac_en, ram_wr} !== 3'b000) begin
        fails++; $display("FAIL start_unloaded: busy/mac_en/ram_wr=%b, required 000", {busy, mac_en, ram_wr}); end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load(input int gap_at, input int gap_len, input bit ones);
    int p = 0, g = 0, writes = 0, cyc = 0;
    logic [7:0] d;
    logic [5:0] ea;
    wexp_t e;
    while (writes < 64 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ram_wr) begin
        tests++;
        if (wq.size() == 0) begin
          fails++; $display("FAIL load_unexpected_write: addr=%0d, required no write", ram_addr);
        end else begin
          e = wq.pop_front();
          ea = e.addr[5:0];
          d = e.data[7:0];
          if (ram_addr !== ea || ram_din !== d) begin
            fails++; $display("FAIL load_write: addr=%0d din=%0h, required addr=%0d din=%0h", ram_addr, ram_din, ea, d); end
        end
        writes++;
        tests++;
        if ({loaded, busy} !== ((writes == 64) ? 2'b10 : 2'b01)) begin
          fails++; $display("FAIL load_flags: write %0d loaded/busy=%b", writes, {loaded, busy}); end
      end
      if (p < 64) begin
        if (p == gap_at && g < gap_len) begin
          in_st = 1'b0;
          g++;
        end else begin
          d = ones ? 8'd1 : 8'(p - 32);
          in_st = 1'b1;
          in_data = d;
          img_ref[p] = int'($signed(d));
          e.addr = p;
          e.data = int'(d);
          wq.push_back(e);
          p++;
        end
      end else begin
        in_st = 1'b0;
      end
    end
    in_st = 1'b0;
    tests++;
    if (writes != 64 || wq.size() != 0) begin
      fails++; $display("FAIL load_count: writes=%0d pending=%0d, required 64 and 0", writes, wq.size()); end
    @(negedge clk);
  endtask

  task automatic test_conv(input bit inject);
    oexp_t e;
    int s, tp;
    logic [5:0] ea;
    for (int k = 0; k < 36; k++) begin
      s = 0;
      for (int ky = 0; ky < 3; ky++)
        for (int kx = 0; kx < 3; kx++)
          s += img_ref[((k / 6) + ky) * 8 + (k % 6) + kx];
      e.idx = k; e.val = s; e.cyc = 10 + 9 * k;
      oq.push_back(e);
    end
    start = 1'b1;
    for (int cyc = 0; cyc < 330; cyc++) begin
      @(negedge clk);
      if (cyc == 0) start = 1'b0;
      tests++;
      if (ram_wr !== 1'b0) begin
        fails++; $display("FAIL conv_no_write: cycle %0d ram_wr=%b, required 0", cyc, ram_wr); end
      tests++;
      if (mac_en !== (cyc >= 1 && cyc <= 324)) begin
        fails++; $display("FAIL conv_mac_en: cycle %0d mac_en=%b", cyc, mac_en); end
      if (mac_en) begin
        tp = (cyc - 1) % 9;
        tests++;
        if (tap_idx !== 4'(tp) || mac_clr !== (tp == 0)) begin
          fails++; $display("FAIL conv_tap: cycle %0d tap=%0d clr=%b, required tap=%0d clr=%b", cyc, tap_idx, mac_clr, tp, tp == 0); end
      end
      if (cyc >= 63 && cyc <= 71) begin
        tp = cyc - 63;
        ea = 6'((1 + tp / 3) * 8 + 1 + tp % 3);
        tests++;
        if (ram_addr !== ea) begin
          fails++; $display("FAIL conv_window7_addr: tap %0d addr=%0d, required %0d", tp, ram_addr, ea); end
      end
      if (out_st) begin
        tests++;
        if (oq.size() == 0) begin
          fails++; $display("FAIL conv_extra_out: cycle %0d idx=%0d", cyc, out_idx);
        end else begin
          e = oq.pop_front();
          if (out_idx !== 6'(e.idx) || acc !== e.val || cyc != e.cyc) begin
            fails++; $display("FAIL conv_out: idx=%0d val=%0d cyc=%0d, required idx=%0d val=%0d cyc=%0d", out_idx, acc, cyc, e.idx, e.val, e.cyc); end
        end
      end
      tests++;
      if (done !== (cyc == 326) || busy !== (cyc < 327)) begin
        fails++; $display("FAIL conv_done_busy: cycle %0d done=%b busy=%b", cyc, done, busy); end
      if (inject && cyc == 50) begin start = 1'b1; in_st = 1'b1; in_data = 8'h55; end
      if (inject && cyc == 53) begin start = 1'b0; in_st = 1'b0; end
    end
    tests++;
    if (oq.size() != 0 || loaded !== 1'b1) begin
      fails++; $display("FAIL conv_end: pending outputs=%0d loaded=%b, required 0 and 1", oq.size(), loaded); end
    oq.delete();
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    for (int cyc = 0; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (cyc == 0) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({ram_wr, ram_addr, ram_din, tap_idx, mac_clr, mac_en, out_st, out_idx, loaded, busy, done} !== '0) begin
      fails++; $display("FAIL reset_mid_outputs: outputs not all 0 during reset"); end
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    repeat (5) begin
      @(negedge clk);
      tests++;
      if ({busy, mac_en, loaded} !== 3'b000) begin
        fails++; $display("FAIL reset_mid_start_ignored: busy/mac_en/loaded=%b, required 000", {busy, mac_en, loaded}); end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_start_unloaded();
    test_load(-1, 0, 1'b0);
    test_conv(1'b0);
    test_load(20, 3, 1'b1);
    test_conv(1'b1);
    test_reset_mid();
    test_load(-1, 0, 1'b1);
    test_conv(1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
